// File: rtl/alien_march_ctrl_pkg.sv
// alien_march_ctrl_pkg: formation geometry shared by march, collision and shot logic
package alien_march_ctrl_pkg;
  localparam int SCREEN_W = 160;
  localparam int A_WIDTH = 13;
  localparam int A_HEIGHT = 8;
  localparam int A_X_DIST = 5;
  localparam int A_Y_DIST = 4;
  localparam int A_NUM_PER_ROW = 5;
  localparam int A_NUM_ROWS = 3;
  localparam int A_PITCH = A_WIDTH + A_X_DIST;
  localparam int A_COUNT = A_NUM_PER_ROW * A_NUM_ROWS;
  typedef enum logic [1:0] {WAIT, SCAN, MOVE} march_state_t;
endpackage

// File: rtl/alien_march_ctrl_period_calc.sv
// march_period_calc: alive count to clamped step period, never wrapping below zero
module march_period_calc #(
  parameter logic [29:0] BASE_PERIOD = 30'd2000000,
  parameter logic [29:0] PERIOD_DEC = 30'd120000,
  parameter logic [29:0] MIN_PERIOD = 30'd200000
) (
  input  logic [3:0]  cnt,
  output logic [29:0] period
);
  logic [29:0] dec;
  always_comb begin
    dec = {26'd0, 4'd15 - cnt} * PERIOD_DEC;
    period = (dec >= BASE_PERIOD) ? MIN_PERIOD :
             (BASE_PERIOD - dec < MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD - dec;
  end
endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: step timer, column scan and edge-reversing march of the alien formation
module alien_march_ctrl
  import alien_march_ctrl_pkg::*;
#(
  parameter int STEP_X = 1,
  parameter int STEP_Y = 4,
  parameter logic [29:0] BASE_PERIOD = 30'd2000000,
  parameter logic [29:0] PERIOD_DEC = 30'd120000,
  parameter logic [29:0] MIN_PERIOD = 30'd200000,
  parameter logic [7:0] START_X = 8'd10,
  parameter logic [7:0] START_Y = 8'd10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [14:0] alive,
  output logic [7:0]  alienX,
  output logic [7:0]  alienY,
  output logic        dir,
  output logic        step_pulse,
  output logic        all_dead
);
  localparam logic [2:0] LAST_COL = 3'(A_NUM_PER_ROW - 1);
  march_state_t state, state_n;
  logic [29:0] timer, period, period_n;
  logic [14:0] alive_q;
  logic [2:0] col, maxc;
  logic [3:0] cnt, col4;
  logic any, expire, b0, b1, b2, occ, hit_r, hit_l;
  logic [1:0] pc;
  logic [8:0] right;
  logic [7:0] y_next;
  march_period_calc #(
    .BASE_PERIOD(BASE_PERIOD),
    .PERIOD_DEC(PERIOD_DEC),
    .MIN_PERIOD(MIN_PERIOD)
  ) u_period (
    .cnt(cnt),
    .period(period_n)
  );
  always_comb begin
    col4 = {1'b0, col};
    b0 = alive_q[col4];
    b1 = alive_q[col4 + 4'd5];
    b2 = alive_q[col4 + 4'd10];
    occ = b0 | b1 | b2;
    pc = {1'b0, b0} + {1'b0, b1} + {1'b0, b2};
    expire = timer == period - 30'd1;
    right = {1'b0, alienX} + 9'(maxc) * 9'(A_PITCH) + 9'(A_WIDTH);
    hit_r = dir && (right + 9'(STEP_X) > 9'(SCREEN_W - 1));
    hit_l = !dir && (alienX < 8'(STEP_X));
    // descent saturates so the formation never wraps back to the top
    y_next = ({1'b0, alienY} + 9'(STEP_Y) > 9'd255) ? 8'd255 : alienY + 8'(STEP_Y);
    state_n = state == WAIT ? ((enable && expire) ? SCAN : WAIT) :
              state == SCAN ? ((col == LAST_COL) ? MOVE : SCAN) : WAIT;
  end
  always_ff @(posedge clock)
    state <= !reset ? WAIT : state_n;
  always_ff @(posedge clock) begin
    if (!reset) begin
      alienX <= START_X;
      alienY <= START_Y;
      dir <= 1'b1;
      step_pulse <= 1'b0;
      all_dead <= 1'b0;
      timer <= 30'd0;
      period <= BASE_PERIOD;
      alive_q <= 15'd0;
      col <= 3'd0;
      cnt <= 4'd0;
      maxc <= 3'd0;
      any <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (state == WAIT && enable) begin
        timer <= expire ? 30'd0 : timer + 30'd1;
        if (expire) begin
          alive_q <= alive;
          col <= 3'd0;
          cnt <= 4'd0;
          maxc <= 3'd0;
          any <= 1'b0;
        end
      end
      if (state == SCAN) begin
        cnt <= cnt + {2'b0, pc};
        col <= col + 3'd1;
        if (occ) begin
          maxc <= col;
          any <= 1'b1;
        end
      end
      if (state == MOVE) begin
        period <= period_n;
        all_dead <= !any;
        if (any) begin
          step_pulse <= 1'b1;
          alienY <= (hit_r || hit_l) ? y_next : alienY;
          dir <= hit_r ? 1'b0 : hit_l ? 1'b1 : dir;
          alienX <= (hit_r || hit_l) ? alienX : dir ? alienX + 8'(STEP_X) : alienX - 8'(STEP_X);
        end
      end
    end
  end
endmodule

// File: tb/tb_alien_march_ctrl.sv
// tb_alien_march_ctrl: directed checks of march timing, edge turns, period scaling and reset
module tb_alien_march_ctrl;
  logic clock = 1'b0;
  logic reset, enable;
  logic [14:0] alive, alive2;
  logic [7:0] alienX, alienY, alienX2, alienY2;
  logic dir, step_pulse, all_dead, dir2, step_pulse2, all_dead2;
  int checks = 0, errors = 0, cyc = 0, n = 0;
  logic seen;
  int p2[$];
  alien_march_ctrl #(.BASE_PERIOD(30'd20), .PERIOD_DEC(30'd1), .MIN_PERIOD(30'd4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .alive(alive),
    .alienX(alienX), .alienY(alienY), .dir(dir), .step_pulse(step_pulse), .all_dead(all_dead)
  );
  alien_march_ctrl #(.BASE_PERIOD(30'd20), .PERIOD_DEC(30'd1), .MIN_PERIOD(30'd8)) u_clamp (
    .clock(clock), .reset(reset), .enable(enable), .alive(alive2),
    .alienX(alienX2), .alienY(alienY2), .dir(dir2), .step_pulse(step_pulse2), .all_dead(all_dead2)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (step_pulse2) p2.push_back(cyc);
  endtask
  task automatic step_wait(input int limit, output int cnt_o);
    cnt_o = 0;
    do begin
      tick();
      cnt_o++;
    end while (!step_pulse && cnt_o < limit);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b0;
    enable = 1'b1;
    alive = 15'h7fff;
    alive2 = 15'h7fff;
    tick();
    tick();
    chk("rst_x", 32'(alienX), 32'd10);
    chk("rst_y", 32'(alienY), 32'd10);
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    chk("rst_dead", 32'(all_dead), 32'd0);
    reset = 1'b1;
    step_wait(100, n);
    chk("first_lat", 32'(n), 32'd26);
    chk("first_x", 32'(alienX), 32'd11);
    chk("first_y", 32'(alienY), 32'd10);
    tick();
    chk("pulse_width", 32'(step_pulse), 32'd0);
    step_wait(60, n);
    chk("interval_full", 32'(n), 32'd25);
    for (int k = 3; k <= 64; k++) step_wait(60, n);
    chk("s64_x", 32'(alienX), 32'd74);
    chk("s64_y", 32'(alienY), 32'd10);
    chk("s64_dir", 32'(dir), 32'd1);
    chk("s64_int", 32'(n), 32'd26);
    step_wait(60, n);
    chk("s65_x", 32'(alienX), 32'd74);
    chk("s65_y", 32'(alienY), 32'd14);
    chk("s65_dir", 32'(dir), 32'd0);
    for (int k = 66; k <= 139; k++) step_wait(60, n);
    chk("s139_x", 32'(alienX), 32'd0);
    chk("s139_dir", 32'(dir), 32'd0);
    step_wait(60, n);
    chk("s140_x", 32'(alienX), 32'd0);
    chk("s140_y", 32'(alienY), 32'd18);
    chk("s140_dir", 32'(dir), 32'd1);
    step_wait(60, n);
    chk("s141_x", 32'(alienX), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (step_pulse) seen = 1'b1;
    end
    chk("hold_nopulse", 32'(seen), 32'd0);
    chk("hold_x", 32'(alienX), 32'd1);
    enable = 1'b1;
    step_wait(60, n);
    chk("resume_lat", 32'(n), 32'd21);
    chk("resume_x", 32'(alienX), 32'd2);
    for (int i = 0; i < 22; i++) tick();
    reset = 1'b0;
    tick();
    chk("midscan_x", 32'(alienX), 32'd10);
    chk("midscan_y", 32'(alienY), 32'd10);
    chk("midscan_dir", 32'(dir), 32'd1);
    chk("midscan_pulse", 32'(step_pulse), 32'd0);
    alive = 15'b011110111101111;
    reset = 1'b1;
    step_wait(100, n);
    chk("c4_first", 32'(n), 32'd26);
    step_wait(60, n);
    chk("c4_int", 32'(n), 32'd23);
    chk("c4_x2", 32'(alienX), 32'd12);
    for (int k = 3; k <= 82; k++) step_wait(60, n);
    chk("c4_s82_x", 32'(alienX), 32'd92);
    chk("c4_s82_dir", 32'(dir), 32'd1);
    step_wait(60, n);
    chk("c4_s83_x", 32'(alienX), 32'd92);
    chk("c4_s83_y", 32'(alienY), 32'd14);
    chk("c4_s83_dir", 32'(dir), 32'd0);
    reset = 1'b0;
    tick();
    alive = 15'd0;
    alive2 = 15'h0001;
    reset = 1'b1;
    p2.delete();
    n = 0;
    seen = 1'b0;
    do begin
      tick();
      n++;
      if (step_pulse) seen = 1'b1;
    end while (!all_dead && n < 60);
    chk("dead_lat", 32'(n), 32'd26);
    chk("dead_nopulse", 32'(seen), 32'd0);
    chk("dead_x", 32'(alienX), 32'd10);
    chk("dead_y", 32'(alienY), 32'd10);
    alive = 15'h0001;
    step_wait(60, n);
    chk("dead15_int", 32'(n), 32'd11);
    chk("revive_x", 32'(alienX), 32'd11);
    chk("revive_dead", 32'(all_dead), 32'd0);
    step_wait(60, n);
    chk("dead14_int", 32'(n), 32'd12);
    chk("clamp_cnt", 32'(p2.size() >= 2), 32'd1);
    chk("clamp_int", (p2.size() >= 2) ? 32'(p2[1] - p2[0]) : 32'hffffffff, 32'd14);
    chk("clamp_dead", 32'(all_dead2), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
